// File: rtl/pixel_write_arbiter.sv
// Frame sequencer and round-robin arbiter for the display's single pixel write port.
// Optional macro PIXEL_WRITE_HAZARD_STALL_EN stalls back-to-back same-address accepts.
module pixel_write_arbiter #(
   parameter int unsigned N_REQ         = 4,
   parameter int unsigned ADDR_WIDTH    = 15,
   parameter int unsigned FB_DATA_WIDTH = 4,
   parameter int unsigned DB_DATA_WIDTH = 12
) (
   input  logic                             clk,
   input  logic                             rstn,
   input  logic                             i_frame_start,
   output logic                             o_busy,
   output logic                             o_frame_done,
   input  logic [N_REQ-1:0]                 i_req_valid,
   input  logic [N_REQ-1:0]                 i_req_last,
   input  logic [N_REQ*ADDR_WIDTH-1:0]      i_req_addr,
   input  logic [N_REQ*FB_DATA_WIDTH-1:0]   i_req_fb_data,
   input  logic [N_REQ*DB_DATA_WIDTH-1:0]   i_req_db_data,
   output logic [N_REQ-1:0]                 o_req_ready,
   output logic                             o_clear,
   input  logic                             i_disp_ready,
   output logic                             o_pixel_write_valid,
   output logic [ADDR_WIDTH-1:0]            o_pixel_write_addr,
   output logic [FB_DATA_WIDTH-1:0]         o_fb_data,
   output logic [DB_DATA_WIDTH-1:0]         o_db_data
);

   localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [2:0] {
      StIdle,
      StClear,
      StWaitClr,
      StDraw,
      StDone
   } state_e;

   state_e                   state_q, state_d;
   logic                     wait_first_q, wait_first_d;
   logic [IDX_W-1:0]         rr_q, rr_d;
   logic [N_REQ-1:0]         done_q, done_d;

   logic                     pix_valid_q;
   logic [ADDR_WIDTH-1:0]    pix_addr_q;
   logic [FB_DATA_WIDTH-1:0] pix_fb_q;
   logic [DB_DATA_WIDTH-1:0] pix_db_q;

   logic                     cand_found;
   logic [IDX_W-1:0]         cand_idx;
   logic [IDX_W-1:0]         scan_idx;
   logic [ADDR_WIDTH-1:0]    cand_addr;
   logic                     hazard;
   logic                     grant;

   // Round-robin search starting at the pointer, skipping finished requesters.
   always_comb begin
      cand_found = 1'b0;
      cand_idx   = '0;
      scan_idx   = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         scan_idx = IDX_W'((32'(rr_q) + i) % N_REQ);
         if (!cand_found && i_req_valid[scan_idx] && !done_q[scan_idx]) begin
            cand_found = 1'b1;
            cand_idx   = scan_idx;
         end
      end
   end

   assign cand_addr = i_req_addr[cand_idx*ADDR_WIDTH +: ADDR_WIDTH];

`ifdef PIXEL_WRITE_HAZARD_STALL_EN
   // The registered beat is exactly last cycle's accept; its depth read is still in flight.
   assign hazard = pix_valid_q && (cand_addr == pix_addr_q);
`else
   assign hazard = 1'b0;
`endif

   assign grant = (state_q == StDraw) && cand_found && !hazard;

   always_comb begin
      o_req_ready = '0;
      if (grant) begin
         o_req_ready[cand_idx] = 1'b1;
      end
   end

   always_comb begin
      state_d      = state_q;
      wait_first_d = 1'b0;
      rr_d         = rr_q;
      done_d       = done_q;

      if (grant) begin
         rr_d = (cand_idx == IDX_W'(N_REQ - 1)) ? '0 : cand_idx + 1'b1;
         if (i_req_last[cand_idx]) begin
            done_d[cand_idx] = 1'b1;
         end
      end

      unique case (state_q)
         StIdle: begin
            if (i_frame_start) begin
               state_d = StClear;
            end
         end
         StClear: begin
            done_d       = '0;
            wait_first_d = 1'b1;
            state_d      = StWaitClr;
         end
         StWaitClr: begin
            // Ready is stale on the first cycle while the display drops it.
            if (!wait_first_q && i_disp_ready) begin
               state_d = StDraw;
            end
         end
         StDraw: begin
            // Looking at next-state flags lets the final beat land in the DONE cycle.
            if (&done_d) begin
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= StIdle;
         wait_first_q <= 1'b0;
         rr_q         <= '0;
         done_q       <= '0;
      end else begin
         state_q      <= state_d;
         wait_first_q <= wait_first_d;
         rr_q         <= rr_d;
         done_q       <= done_d;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pix_valid_q <= 1'b0;
         pix_addr_q  <= '0;
         pix_fb_q    <= '0;
         pix_db_q    <= '0;
      end else begin
         pix_valid_q <= grant;
         if (grant) begin
            pix_addr_q <= cand_addr;
            pix_fb_q   <= i_req_fb_data[cand_idx*FB_DATA_WIDTH +: FB_DATA_WIDTH];
            pix_db_q   <= i_req_db_data[cand_idx*DB_DATA_WIDTH +: DB_DATA_WIDTH];
         end
      end
   end

   assign o_busy              = (state_q != StIdle);
   assign o_clear             = (state_q == StClear);
   assign o_frame_done        = (state_q == StDone);
   assign o_pixel_write_valid = pix_valid_q;
   assign o_pixel_write_addr  = pix_addr_q;
   assign o_fb_data           = pix_fb_q;
   assign o_db_data           = pix_db_q;

`ifndef SYNTHESIS
   a_ready_onehot : assert property (@(posedge clk) disable iff (!rstn)
      $onehot0(o_req_ready));
   a_ready_draw_only : assert property (@(posedge clk) disable iff (!rstn)
      (|o_req_ready) |-> (state_q == StDraw));
   a_ready_not_done : assert property (@(posedge clk) disable iff (!rstn)
      (o_req_ready & done_q) == '0);
   a_clear_pulse : assert property (@(posedge clk) disable iff (!rstn)
      o_clear |=> !o_clear);
   a_done_pulse : assert property (@(posedge clk) disable iff (!rstn)
      o_frame_done |=> !o_frame_done);
`endif

endmodule
